// File: rtl/data_memory_ctrl.sv
// Parametrised single-port data RAM with byte enables, valid/ready request port,
// range checking, 1- or 2-cycle pipelined responses and a hardware zeroing sweep.
module data_memory_ctrl #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic                clear,
   output logic                init_busy,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_CLEAR
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   cnt;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic               accept;
   logic               in_range;
   logic [IDX_W-1:0]   idx;

   logic               s1_valid;
   logic               s1_err;
   logic [DATA_W-1:0]  s1_rdata;

   assign req_ready = (state == ST_RUN) && !clear;
   assign init_busy = (state != ST_RUN);
   assign accept    = req_valid && req_ready;
   // Full-width compare so out-of-range addresses never alias onto real words.
   assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
   assign idx       = req_addr[IDX_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (clear) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
               end
            end
            default: begin
               if (cnt == IDX_W'(DEPTH - 1)) begin
                  state <= ST_RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + IDX_W'(1);
               end
            end
         endcase
      end
   end

   // The array has no reset; the sweep is what brings it to a known state.
   always_ff @(posedge clk) begin
      if (state != ST_RUN) begin
         mem[cnt] <= '0;
      end else if (accept && req_write && in_range) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (req_be[b]) begin
               mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         s1_rdata <= '0;
      end else begin
         s1_valid <= accept;
         s1_err   <= accept && !in_range;
         s1_rdata <= (accept && !req_write && in_range) ? mem[idx] : '0;
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic              s2_valid;
         logic              s2_err;
         logic [DATA_W-1:0] s2_rdata;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid <= 1'b0;
               s2_err   <= 1'b0;
               s2_rdata <= '0;
            end else begin
               s2_valid <= s1_valid;
               s2_err   <= s1_err;
               s2_rdata <= s1_rdata;
            end
         end

         assign rsp_valid = s2_valid;
         assign rsp_err   = s2_err;
         assign rsp_rdata = s2_rdata;
      end else begin : g_lat1
         assign rsp_valid = s1_valid;
         assign rsp_err   = s1_err;
         assign rsp_rdata = s1_rdata;
      end
   endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: expected responses are queued at issue
// time from a reference memory model and compared as the DUT emits them.
module tb_data_memory_ctrl;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned DEPTH    = 32;
   localparam int unsigned READ_LAT = 1;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              err;
      int                cyc;
   } rsp_exp_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic                req_write = 1'b0;
   logic [ADDR_W-1:0]   req_addr = '0;
   logic [DATA_W-1:0]   req_wdata = '0;
   logic [DATA_W/8-1:0] req_be = '0;
   logic                clear = 1'b0;
   logic                init_busy;
   logic                rsp_valid;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_err;

   int                  checks = 0;
   int                  failures = 0;
   int                  cyc = 0;
   rsp_exp_t            exp_q[$];
   rsp_exp_t            mon_e;
   logic [DATA_W-1:0]   model [DEPTH];

   data_memory_ctrl #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .READ_LAT (READ_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .clear     (clear),
      .init_busy (init_busy),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h err=%b at cycle %0d, required no response",
                        rsp_rdata, rsp_err, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               if (rsp_rdata !== mon_e.data || rsp_err !== mon_e.err || cyc !== mon_e.cyc) begin
                  failures++;
                  $display("FAIL rsp: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                           rsp_rdata, rsp_err, cyc, mon_e.data, mon_e.err, mon_e.cyc);
               end
            end
         end else if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL idle_rsp: got rdata=%h err=%b with rsp_valid=0, required 0/0", rsp_rdata, rsp_err);
         end
      end
   end

   // Drives one request for a single cycle and queues its predicted response.
   task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W/8-1:0] be);
      rsp_exp_t e;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      @(negedge clk);
      e.err  = (int'(addr) >= DEPTH);
      e.data = '0;
      e.cyc  = cyc + int'(READ_LAT);
      if (!e.err) begin
         if (!wr) begin
            e.data = model[addr];
         end else begin
            for (int b = 0; b < DATA_W/8; b++) begin
               if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
            end
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      bit done;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || init_busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b busy=%b, required 0/0000/0/1",
                  rsp_valid, rsp_rdata, rsp_err, init_busy);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'd5;
      rst_n     = 1'b1;
      n = 0;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) begin
            done = 1'b1;
         end else if (init_busy === 1'b1) begin
            n++;
         end
      end
      checks++;
      if (!done || n != 32) begin
         failures++;
         $display("FAIL init_sweep_len: got %0d busy cycles (ready seen=%0d), required 32", n, done);
      end
      if (done) exp_q.push_back('{data: '0, err: 1'b0, cyc: cyc + int'(READ_LAT)});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (READ_LAT + 2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL reset_drain: got %0d pending responses, required 0", exp_q.size());
      end
   endtask

   task automatic test_byte_enable();
      issue(1'b1, 8'd3, 16'hBEEF, 2'b11);
      issue(1'b1, 8'd3, 16'h12AA, 2'b10);
      issue(1'b0, 8'd3, 16'h0000, 2'b00);
      repeat (READ_LAT + 2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL byte_enable_drain: got %0d pending responses, required 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 8'd7, 16'hA5A5, 2'b11);
      issue(1'b0, 8'd7, 16'h0000, 2'b00);
      issue(1'b0, 8'd8, 16'h0000, 2'b00);
      repeat (READ_LAT + 2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL back_to_back_drain: got %0d pending responses, required 0", exp_q.size());
      end
   endtask

   task automatic test_out_of_range();
      issue(1'b1, 8'd40, 16'hFFFF, 2'b11);
      issue(1'b0, 8'd40, 16'h0000, 2'b00);
      issue(1'b0, 8'd8,  16'h0000, 2'b00);
      issue(1'b1, 8'd31, 16'h1234, 2'b11);
      issue(1'b0, 8'd31, 16'h0000, 2'b00);
      issue(1'b1, 8'd32, 16'h5555, 2'b11);
      issue(1'b0, 8'd32, 16'h0000, 2'b00);
      issue(1'b0, 8'd0,  16'h0000, 2'b00);
      issue(1'b0, 8'd255, 16'h0000, 2'b00);
      repeat (READ_LAT + 2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL out_of_range_drain: got %0d pending responses, required 0", exp_q.size());
      end
   endtask

   task automatic test_clear();
      int n;
      issue(1'b0, 8'd3, 16'h0000, 2'b00);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'd3;
      clear     = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL clear_priority: got req_ready=%b with clear, required 0", req_ready);
      end
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      @(posedge clk);
      #1;
      clear     = 1'b0;
      req_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (init_busy !== 1'b1) break;
         n++;
         clear = (n == 10);
      end
      clear = 1'b0;
      checks++;
      if (n != 32) begin
         failures++;
         $display("FAIL clear_sweep_len: got %0d busy cycles, required 32", n);
      end
      @(posedge clk);
      #1;
      issue(1'b0, 8'd3, 16'h0000, 2'b00);
      issue(1'b0, 8'd31, 16'h0000, 2'b00);
      repeat (READ_LAT + 2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL clear_drain: got %0d pending responses, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      issue(1'b1, 8'd9, 16'h3C3C, 2'b11);
      issue(1'b0, 8'd9, 16'h0000, 2'b00);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_flush: got rsp_valid=%b init_busy=%b in reset, required 0/1", rsp_valid, init_busy);
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (init_busy !== 1'b1) break;
         n++;
      end
      checks++;
      if (n != 32) begin
         failures++;
         $display("FAIL reinit_sweep_len: got %0d busy cycles, required 32", n);
      end
      @(posedge clk);
      #1;
      issue(1'b0, 8'd9, 16'h0000, 2'b00);
      repeat (READ_LAT + 2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL reinit_drain: got %0d pending responses, required 0", exp_q.size());
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_byte_enable();
      test_back_to_back();
      test_out_of_range();
      test_clear();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the core's single-port data RAM.
- Adds configurable width and depth, per-byte write enables, and a valid/ready request port.
- Read latency is 1 or 2 cycles (pipelined), and out-of-range accesses are flagged.
- A hardware zeroing sweep runs after reset and on demand.
- Sits between the execute stage (address from the ALU) and the register-file writeback path.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8 and ≥8
- ADDR_W, 8, request address width (word addressed)
- DEPTH, 32, number of words implemented; 2 ≤ DEPTH ≤ 2^ADDR_W
- READ_LAT, 1, read latency in cycles from accept to response; legal values 1 or 2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; bit i covers bits [8i+7:8i]
- clear  in  1  one-cycle pulse; starts a zeroing sweep
- init_busy  out  1  zeroing sweep in progress
- rsp_valid  out  1  response valid (one cycle per accepted request)
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  accepted address was ≥ DEPTH

Behaviour:
- Reset (async, rst_n=0):
  - FSM → INIT, sweep counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_busy = 1.
  - Response pipeline flushed.
  - The array itself is not reset; it is zeroed by the sweep.
- FSM states INIT, RUN, CLEAR:
  - INIT/CLEAR write 0 to word[cnt] each cycle, cnt = 0..DEPTH-1, then go to RUN.
  - Each sweep takes exactly DEPTH cycles.
  - init_busy = 1 in INIT and CLEAR.
- RUN: a clear pulse moves to CLEAR with cnt = 0.
  - clear seen in INIT or CLEAR is ignored; the sweep is not restarted.
- req_ready = (state == RUN) && !clear. Clear has priority over a same-cycle request.
- Accept = req_valid && req_ready. Inputs are sampled only on accept.
- Write accept:
  - If addr < DEPTH, bytes with req_be=1 are updated at that clock edge; other bytes are kept.
  - A response follows with rsp_rdata = 0.
- Read accept:
  - Data is read from the array on the accept edge.
  - Response appears READ_LAT cycles after the accept edge.
- Write responses use the same latency as reads, so responses stay in order.
- One response per accepted request; back-to-back accepts give back-to-back responses. Throughput is 1 per cycle.
- No response backpressure: the consumer must always take responses.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. A write and a read cannot be accepted in the same cycle (single port).
- Out of range (addr ≥ DEPTH):
  - A write is dropped.
  - A read returns rsp_rdata = 0.
  - In both cases rsp_err = 1 with the response.
  - Address bits above clog2(DEPTH) are compared, not truncated.
- Responses already in flight when CLEAR starts are still delivered with their pre-clear data.
- Reset mid-sweep or mid-pipeline: the pipeline is flushed with no response emitted, and the sweep restarts from 0.
- rsp_valid = 0 on every cycle with no response; rsp_rdata and rsp_err are 0 whenever rsp_valid = 0.

Test Plan:
1. Release rst_n, hold req_valid=1 → req_ready=0 and init_busy=1 for exactly 32 cycles, then req_ready=1. The first read of addr 5 returns 0x0000 with rsp_err=0.
2. Write addr 3 = 0xBEEF with be=11, then write addr 3 = 0x12xx with be=10, then read addr 3 → rsp_rdata = 0x12EF. With READ_LAT=1, rsp_valid is exactly 1 cycle after the accept; with READ_LAT=2, exactly 2 cycles after.
3. Back-to-back sequence write 7=0xA5A5, read 7, read 8 on consecutive cycles → three consecutive rsp_valid pulses with data 0x0000, 0xA5A5, 0x0000.
4. Write addr 40 = 0xFFFF, then read addr 40 and read addr 8 → rsp_err=1 with rdata 0 for both addr-40 accesses; addr 8 is unchanged (0x0000).
5. Issue a read of addr 3 (holding 0x12EF) on the same cycle as a clear pulse → request not accepted (req_ready=0). Issue the read one cycle before the clear → response 0x12EF still delivered. After 32 busy cycles, a read of addr 3 returns 0x0000.
6. Assert rst_n=0 mid-clear with a read in flight → no rsp_valid is emitted. After release, init_busy=1 for a full 32 cycles.
